rv32_fetch: RTL and testbench

Instruction fetch stage of the RV32 pipeline, directly upstream of decode and driven by the hazard unit's fetch stall/flush outputs. Holds the PC and drives the instruction bus (`instr_read`/`instr_ready`). Registers the returned instruction and its PC for decode, and redirects to the memory stage's branch target on a misprediction. A redirect that arrives while a bus read is still outstanding is handled by completing that read and discarding its data.

---
 rtl/rv32_fetch_if.sv | 22 ++
 rtl/rv32_fetch.sv | 117 +++++++++++
 tb/tb_rv32_fetch.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_if.sv
// Instruction bus between the RV32 fetch stage (master) and instruction memory (slave).
// The fetch stage holds the address stable from request until the read completes.
interface rv32_fetch_if;
    logic [31:0] instr_address_out;
    logic        instr_read_out;
    logic        instr_ready_in;
    logic [31:0] instr_read_value_in;

    modport master (
        output instr_address_out,
        output instr_read_out,
        input  instr_ready_in,
        input  instr_read_value_in
    );

    modport slave (
        input  instr_address_out,
        input  instr_read_out,
        output instr_ready_in,
        output instr_read_value_in
    );
endinterface

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch stage: PC, instruction bus requests, decode output register, redirects.
// Optional one-entry skid buffer for reads completing under stall: define RV32_FETCH_BUFFER_EN.
module rv32_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_in,
    input  logic         flush_in,
    input  logic         branch_mispredicted_in,
    input  logic [31:0]  branch_pc_in,
    rv32_fetch_if.master bus,
    output logic [31:0]  pc_out,
    output logic [31:0]  instr_out,
    output logic         valid_out
);

    localparam logic [0:0]  FETCH   = 1'b0;
    localparam logic [0:0]  DISCARD = 1'b1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] target;
    logic        read_req;
    logic        done;
    logic        buf_full;

`ifdef RV32_FETCH_BUFFER_EN
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
`else
    assign buf_full = 1'b0;
`endif

    // In DISCARD the outstanding read must run to completion, so the request stays up.
    always_comb begin
        target   = branch_pc_in & 32'hFFFF_FFFC;
        read_req = !reset && ((state == DISCARD) || !buf_full);
        done     = read_req && bus.instr_ready_in;
    end

    assign bus.instr_address_out = pc;
    assign bus.instr_read_out    = read_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_VECTOR;
            pending_pc <= RESET_VECTOR;
            valid_out  <= 1'b0;
            instr_out  <= NOP;
            pc_out     <= RESET_VECTOR;
`ifdef RV32_FETCH_BUFFER_EN
            buf_full   <= 1'b0;
            buf_pc     <= RESET_VECTOR;
            buf_instr  <= NOP;
`endif
        end else if (state == DISCARD) begin
            valid_out <= 1'b0;
            if (done) begin
                pc    <= branch_mispredicted_in ? target : pending_pc;
                state <= FETCH;
            end else if (branch_mispredicted_in) begin
                pending_pc <= target;
            end
        end else if (branch_mispredicted_in) begin
            valid_out <= 1'b0;
            instr_out <= NOP;
`ifdef RV32_FETCH_BUFFER_EN
            buf_full  <= 1'b0;
`endif
            if (done || !read_req) begin
                pc <= target;
            end else begin
                pending_pc <= target;
                state      <= DISCARD;
            end
        end else if (stall_in) begin
`ifdef RV32_FETCH_BUFFER_EN
            if (done) begin
                buf_pc    <= pc;
                buf_instr <= bus.instr_read_value_in;
                buf_full  <= 1'b1;
                pc        <= pc + 32'd4;
            end
`endif
        end
`ifdef RV32_FETCH_BUFFER_EN
        // No read is issued while full, so draining never collides with a completion.
        else if (buf_full) begin
            if (flush_in) begin
                valid_out <= 1'b0;
                instr_out <= NOP;
            end else begin
                pc_out    <= buf_pc;
                instr_out <= buf_instr;
                valid_out <= 1'b1;
                buf_full  <= 1'b0;
            end
        end
`endif
        else if (flush_in) begin
            valid_out <= 1'b0;
            instr_out <= NOP;
        end else if (done) begin
            pc_out    <= pc;
            instr_out <= bus.instr_read_value_in;
            valid_out <= 1'b1;
            pc        <= pc + 32'd4;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: directed vectors, queue-based reference model checked every cycle.
// Exercises the skid-buffer scenario as well when RV32_FETCH_BUFFER_EN is defined.
module tb_rv32_fetch;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        mis;
    logic [31:0] target;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    rv32_fetch_if bus ();

    rv32_fetch #(.RESET_VECTOR(RV)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .stall_in               (stall),
        .flush_in               (flush),
        .branch_mispredicted_in (mis),
        .branch_pc_in           (target),
        .bus                    (bus),
        .pc_out                 (pc_out),
        .instr_out              (instr_out),
        .valid_out              (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h00C0_FFEE;
    endfunction

    assign bus.instr_read_value_in = mem_word(bus.instr_address_out);

    // Reference model: a pending-redirect queue stands for DISCARD, a skid queue for the buffer.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc_out;
    logic [31:0] m_redirect_q[$];
    entry_t      m_skid[$];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelRead();
        return !reset && (m_redirect_q.size() != 0 || m_skid.size() == 0);
    endfunction

    task automatic modelStep();
        bit          rd;
        bit          done;
        logic [31:0] tgt;
        entry_t      e;
        rd   = modelRead();
        done = rd && bus.instr_ready_in;
        tgt  = target & 32'hFFFF_FFFC;
        if (reset) begin
            m_pc = RV; m_valid = 1'b0; m_instr = NOP; m_pc_out = RV;
            m_redirect_q.delete();
            m_skid.delete();
        end else if (m_redirect_q.size() != 0) begin
            if (mis) m_redirect_q[0] = tgt;
            if (done) begin
                m_pc = m_redirect_q[0];
                m_redirect_q.delete();
            end
            m_valid = 1'b0;
        end else if (mis) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_skid.delete();
            if (done || !rd) m_pc = tgt;
            else m_redirect_q.push_back(tgt);
        end else if (stall) begin
`ifdef RV32_FETCH_BUFFER_EN
            if (done) begin
                e.pc = m_pc;
                e.instr = mem_word(m_pc);
                m_skid.push_back(e);
                m_pc = m_pc + 32'd4;
            end
`endif
        end else if (m_skid.size() != 0) begin
            if (flush) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end else begin
                e = m_skid.pop_front();
                m_pc_out = e.pc;
                m_instr  = e.instr;
                m_valid  = 1'b1;
            end
        end else if (flush) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (done) begin
            m_pc_out = m_pc;
            m_instr  = mem_word(m_pc);
            m_valid  = 1'b1;
            m_pc     = m_pc + 32'd4;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("read", {31'd0, bus.instr_read_out}, {31'd0, modelRead()});
            if (modelRead()) checkOutput("addr", bus.instr_address_out, m_pc);
            checkOutput("valid", {31'd0, valid_out}, {31'd0, m_valid});
            checkOutput("instr", instr_out, m_instr);
            checkOutput("pc_out", pc_out, m_pc_out);
        end
    end

    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic m,
                                 input logic [31:0] t, input logic rdy);
        reset = r; stall = s; flush = f; mis = m; target = t;
        bus.instr_ready_in = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        tick(); tick();
        checkOutput("rst_read", {31'd0, bus.instr_read_out}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("rst_instr", instr_out, NOP);
        checkOutput("rst_pc_out", pc_out, 32'h100);
        checkOutput("model_rst_pc", m_pc, 32'h100);
        check_en = 1'b1;

        // Zero-wait bus: consecutive addresses, one-cycle latency.
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("first_addr", bus.instr_address_out, 32'h100);
        tick();
        checkOutput("lat_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("lat_pc_out", pc_out, 32'h100);
        checkOutput("lat_instr", instr_out, mem_word(32'h100));
        checkOutput("addr_104", bus.instr_address_out, 32'h104);
        tick();
        checkOutput("addr_108", bus.instr_address_out, 32'h108);
        checkOutput("pc_out_104", pc_out, 32'h104);
        tick();

        // Three wait states with stall mirroring the bus wait.
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 3; w++) begin
                applyStimulus(0, 1, 0, 0, 32'h0, 0);
                tick();
            end
            applyStimulus(0, 0, 0, 0, 32'h0, 1);
            tick();
        end
        checkOutput("wait_addr", bus.instr_address_out, 32'h118);
        checkOutput("wait_pc_out", pc_out, 32'h114);
        checkOutput("model_wait_pc", m_pc, 32'h118);

`ifndef RV32_FETCH_BUFFER_EN
        applyStimulus(0, 1, 0, 0, 32'h0, 1);
        tick();
        checkOutput("stall_refetch", bus.instr_address_out, 32'h118);
        checkOutput("stall_pc_out", pc_out, 32'h114);
`endif

        applyStimulus(0, 0, 1, 0, 32'h0, 1);
        tick();
        checkOutput("flush_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("flush_instr", instr_out, NOP);
        checkOutput("flush_addr", bus.instr_address_out, 32'h118);

        // Redirect with no read left pending (it completes the same cycle).
        applyStimulus(0, 0, 0, 1, 32'h2003, 1);
        tick();
        checkOutput("redir_addr", bus.instr_address_out, 32'h2000);
        checkOutput("redir_valid", {31'd0, valid_out}, 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        tick();
        checkOutput("redir_pc_out", pc_out, 32'h2000);
        checkOutput("redir_valid2", {31'd0, valid_out}, 32'd1);

        // Redirect during an outstanding read, then a second redirect in DISCARD.
        applyStimulus(0, 0, 0, 1, 32'h3000, 0);
        tick();
        checkOutput("disc_hold1", bus.instr_address_out, 32'h2004);
        applyStimulus(0, 1, 0, 1, 32'h4000, 0);
        tick();
        checkOutput("disc_hold2", bus.instr_address_out, 32'h2004);
        checkOutput("disc_read", {31'd0, bus.instr_read_out}, 32'd1);
        applyStimulus(0, 1, 0, 0, 32'h0, 1);
        tick();
        checkOutput("disc_target", bus.instr_address_out, 32'h4000);
        checkOutput("disc_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("disc_instr", instr_out, NOP);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        tick();
        checkOutput("disc_pc_out", pc_out, 32'h4000);

        // Redirect with one further wait cycle: target two cycles later.
        applyStimulus(0, 0, 0, 1, 32'h5000, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        tick();
        checkOutput("k1_target", bus.instr_address_out, 32'h5000);

        // PC wrap.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        tick();
        checkOutput("wrap_addr", bus.instr_address_out, 32'h0);
        checkOutput("wrap_pc_out", pc_out, 32'hFFFF_FFFC);

`ifdef RV32_FETCH_BUFFER_EN
        applyStimulus(0, 0, 0, 1, 32'h200, 1);
        tick();
        applyStimulus(0, 1, 0, 0, 32'h0, 1);
        tick();
        checkOutput("buf_read1", {31'd0, bus.instr_read_out}, 32'd0);
        tick();
        checkOutput("buf_read2", {31'd0, bus.instr_read_out}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        tick();
        checkOutput("buf_pc_out", pc_out, 32'h200);
        checkOutput("buf_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("buf_addr", bus.instr_address_out, 32'h204);
`endif

        // Mixed directed pattern, including a reset in mid-transaction.
        for (int i = 0; i < 66; i++) begin
            applyStimulus(i == 40, (i % 5) == 2, (i % 7) == 3, (i % 11) == 5,
                          32'h8000 + 32'(i * 16 + (i % 4)), (i % 3) != 1);
            tick();
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
